// File: rtl/bcd_add_sequencer.sv
// bcd_add_sequencer
// Digit-serial BCD adder controller. Captures two DIGITS-wide BCD operands on
// Start, then walks one shared single-digit BCD adder across the digits, least
// significant first, writing one Sum digit per cycle. Accumulate mode reuses
// the current Sum as operand A. Err flags any captured digit above 9.

module bcd_add_sequencer #(
    parameter int DIGITS = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Acc,
    input  logic                  Cin,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    output logic [4*DIGITS-1:0]   Sum,
    output logic                  Cout,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Result of one decimal digit position: corrected digit plus carry out.
    typedef struct packed {
        logic       carry;
        logic [3:0] digit;
    } digit_sum_t;

    // One-digit BCD add. Raw sums above 9 get the +6 correction; this rule is
    // applied unchanged to invalid (>9) input digits as well.
    function automatic digit_sum_t bcd_digit_add(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       c
    );
        logic [4:0] raw;
        logic [4:0] adj;
        digit_sum_t res;
        raw = {1'b0, a} + {1'b0, b} + {4'b0000, c};
        adj = raw + 5'd6;
        if (raw > 5'd9) begin
            res.digit = adj[3:0];
            res.carry = 1'b1;
        end else begin
            res.digit = raw[3:0];
            res.carry = 1'b0;
        end
        return res;
    endfunction

    // True when any packed digit of the operand is outside 0..9.
    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q,     a_d;
    logic [W-1:0]     b_q,     b_d;
    logic [W-1:0]     sum_q,   sum_d;
    logic             cout_q,  cout_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             err_q,   err_d;

    logic [W-1:0]     op_a;
    digit_sum_t       digit_res;

    // Operand A source: the live Sum register in accumulate mode, so the old
    // result is copied before the first digit of the new one is written.
    always_comb begin
        op_a = Acc ? sum_q : A;
    end

    // The shared single-digit adder, fed from the captured operands.
    always_comb begin
        digit_res = bcd_digit_add(a_q[4*idx_q +: 4], b_q[4*idx_q +: 4], carry_q);
    end

    // Next-state and next-output logic for the IDLE -> ADD -> DONE sequence.
    always_comb begin
        // NOTE: every *_d starts from a default so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    a_d     = op_a;
                    b_d     = B;
                    carry_d = Cin;
                    idx_d   = '0;
                    err_d   = has_bad_digit(op_a) | has_bad_digit(B);
                    busy_d  = 1'b1;
                    state_d = ADD;
                end
            end

            ADD: begin
                sum_d[4*idx_q +: 4] = digit_res.digit;
                carry_d             = digit_res.carry;
                if (idx_q == LAST_IDX) begin
                    cout_d  = digit_res.carry;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Single state/output register bank; Reset aborts any operation at once.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            // NOTE: the operand copies are reset too, so Reset leaves no stale
            // operand behind for a later accumulate.
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // values sampled before the edge, independent of statement order.
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign Busy = busy_q;
    assign Done = done_q;
    assign Err  = err_q;

    // Busy marks ADD and Done marks DONE, so they can never overlap.
    busy_done_exclusive : assert property (
        @(posedge Clock) disable iff (Reset) !(busy_q && done_q)
    );

endmodule
